// File: rtl/riscv_decode_exec_display_if.sv
// Signal bundle between the RV32 datapath and the decode/execute/display block.
// The end-of-execution flag is named final_flag because "final" is a reserved word.
interface riscv_decode_exec_display_if;
    logic [3:0]  estado;
    logic [31:0] instrucao;
    logic [31:0] readdata1R;
    logic [31:0] readdata2R;
    logic [3:0]  alucontrol;
    logic        alusrc;
    logic        branch;
    logic [7:0]  pc_lo;
    logic [7:0]  x5_lo;
    logic        final_flag;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] immediate;
    logic        negativo;
    logic [2:0]  tipo;
    logic        aluresult1;
    logic [31:0] aluresult2;
    logic        pcsrc;
    logic [6:0]  display1;
    logic [6:0]  display2;
    logic [6:0]  display3;
    logic [6:0]  display4;
    logic [6:0]  display5;

    modport master (
        output estado, instrucao, readdata1R, readdata2R, alucontrol, alusrc, branch,
               pc_lo, x5_lo, final_flag,
        input  opcode, rd, rs1, rs2, funct3, funct7, immediate, negativo, tipo,
               aluresult1, aluresult2, pcsrc, display1, display2, display3, display4, display5
    );

    modport slave (
        input  estado, instrucao, readdata1R, readdata2R, alucontrol, alusrc, branch,
               pc_lo, x5_lo, final_flag,
        output opcode, rd, rs1, rs2, funct3, funct7, immediate, negativo, tipo,
               aluresult1, aluresult2, pcsrc, display1, display2, display3, display4, display5
    );
endinterface

// File: rtl/riscv_decode_exec_display.sv
// RV32 decode-field capture, single-cycle ALU capture and seven-segment status display.
// Decode registers load in ST_ID, ALU registers load in ST_EX; displays are purely combinational.
module riscv_decode_exec_display #(
    parameter logic [3:0] ST_ID = 4'b0001,
    parameter logic [3:0] ST_EX = 4'b0010
) (
    input logic                          clk,
    input logic                          rst,
    riscv_decode_exec_display_if.slave   bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0]  opcode_q;
    logic [4:0]  rd_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [11:0] imm_q;
    logic        neg_q;
    logic [2:0]  tipo_q;
    logic        zero_q;
    logic [31:0] result_q;
    logic        pcsrc_q;

    logic [2:0]  tipo_d;
    logic [11:0] imm_d;
    logic        neg_d;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result_d;

    // Class, immediate and sign come straight from the incoming instruction word.
    always_comb begin
        tipo_d = 3'd7;
        imm_d  = 12'd0;
        neg_d  = 1'b0;
        case (bus.instrucao[6:0])
            OP_R: tipo_d = 3'd0;
            OP_I: begin
                tipo_d = 3'd1;
                imm_d  = bus.instrucao[31:20];
                neg_d  = bus.instrucao[31];
            end
            OP_LOAD: begin
                tipo_d = 3'd2;
                imm_d  = bus.instrucao[31:20];
                neg_d  = bus.instrucao[31];
            end
            OP_STORE: begin
                tipo_d = 3'd3;
                imm_d  = {bus.instrucao[31:25], bus.instrucao[11:7]};
                neg_d  = bus.instrucao[31];
            end
            OP_BRANCH: begin
                tipo_d = 3'd4;
                imm_d  = {bus.instrucao[31], bus.instrucao[7], bus.instrucao[30:25],
                          bus.instrucao[11:8]};
                neg_d  = bus.instrucao[31];
            end
            default: ;
        endcase
    end

    // Operand B uses the captured immediate, so ST_ID must precede ST_EX for I-type ops.
    assign op_a = bus.readdata1R;
    assign op_b = bus.alusrc ? {{20{imm_q[11]}}, imm_q} : bus.readdata2R;

    always_comb begin
        result_d = 32'd0;
        case (bus.alucontrol)
            4'b0000: result_d = op_a & op_b;
            4'b0001: result_d = op_a | op_b;
            4'b0010: result_d = op_a + op_b;
            4'b0011: result_d = op_a ^ op_b;
            4'b0110: result_d = op_a - op_b;
            4'b0100: result_d = op_a << op_b[4:0];
            4'b0101: result_d = op_a >> op_b[4:0];
            4'b1000: result_d = $signed(op_a) >>> op_b[4:0];
            4'b0111: result_d = {31'd0, ($signed(op_a) < $signed(op_b))};
            default: result_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            imm_q    <= '0;
            neg_q    <= 1'b0;
            tipo_q   <= '0;
        end else if (bus.estado == ST_ID) begin
            opcode_q <= bus.instrucao[6:0];
            rd_q     <= bus.instrucao[11:7];
            funct3_q <= bus.instrucao[14:12];
            rs1_q    <= bus.instrucao[19:15];
            rs2_q    <= bus.instrucao[24:20];
            funct7_q <= bus.instrucao[31:25];
            imm_q    <= imm_d;
            neg_q    <= neg_d;
            tipo_q   <= tipo_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            pcsrc_q  <= 1'b0;
        end else if (bus.estado == ST_EX) begin
            result_q <= result_d;
            zero_q   <= (result_d == 32'd0);
            pcsrc_q  <= bus.branch & (result_d == 32'd0);
        end
    end

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign bus.display1 = hex7(bus.pc_lo[3:0]);
    assign bus.display2 = hex7(bus.pc_lo[7:4]);
    assign bus.display3 = hex7(bus.x5_lo[3:0]);
    assign bus.display4 = hex7(bus.x5_lo[7:4]);
    assign bus.display5 = bus.final_flag ? 7'b1111001 : 7'b1000000;

    assign bus.opcode     = opcode_q;
    assign bus.rd         = rd_q;
    assign bus.rs1        = rs1_q;
    assign bus.rs2        = rs2_q;
    assign bus.funct3     = funct3_q;
    assign bus.funct7     = funct7_q;
    assign bus.immediate  = imm_q;
    assign bus.negativo   = neg_q;
    assign bus.tipo       = tipo_q;
    assign bus.aluresult1 = zero_q;
    assign bus.aluresult2 = result_q;
    assign bus.pcsrc      = pcsrc_q;
endmodule

// File: tb/tb_riscv_decode_exec_display.sv
// Directed bench for riscv_decode_exec_display: decode/ALU vector tables, display sweep
// and hand-written reset/hold sequences.
module tb_riscv_decode_exec_display;
    localparam logic [3:0] ST_ID = 4'b0001;
    localparam logic [3:0] ST_EX = 4'b0010;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    riscv_decode_exec_display_if bus ();

    riscv_decode_exec_display #(.ST_ID(ST_ID), .ST_EX(ST_EX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] imm;
        logic [2:0]  tipo;
        logic        neg;
    } dec_vec_t;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic        br;
        logic [31:0] res;
        logic        zero;
        logic        pcsrc;
    } alu_vec_t;

    dec_vec_t   dv[7];
    alu_vec_t   av[13];
    logic [6:0] seg[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".decode"}, {25'd0, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3,
                                  bus.funct7, bus.immediate, bus.negativo, bus.tipo} == 0
                                 ? 32'd0 : 32'd1, 32'd0);
        check({name, ".alu"}, {bus.aluresult1, bus.pcsrc} == 2'b00 ? bus.aluresult2 : 32'hDEAD_BEEF,
              32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        dv[0] = '{32'h00500093, 7'b0010011, 5'd1,  5'd0, 5'd5,  3'd0, 7'h00, 12'h005, 3'd1, 1'b0};
        dv[1] = '{32'h002081B3, 7'b0110011, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 12'h000, 3'd0, 1'b0};
        dv[2] = '{32'h802081B3, 7'b0110011, 5'd3,  5'd1, 5'd2,  3'd0, 7'h40, 12'h000, 3'd0, 1'b0};
        dv[3] = '{32'hFFC12283, 7'b0000011, 5'd5,  5'd2, 5'd28, 3'd2, 7'h7F, 12'hFFC, 3'd2, 1'b1};
        dv[4] = '{32'h00612423, 7'b0100011, 5'd8,  5'd2, 5'd6,  3'd2, 7'h00, 12'h008, 3'd3, 1'b0};
        dv[5] = '{32'h82000AE3, 7'b1100011, 5'd21, 5'd0, 5'd0,  3'd0, 7'h41, 12'hC1A, 3'd4, 1'b1};
        dv[6] = '{32'h923453B7, 7'b0110111, 5'd7,  5'd8, 5'd3,  3'd5, 7'h49, 12'h000, 3'd7, 1'b0};

        av[0]  = '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 32'h00F000F0, 1'b0, 1'b0};
        av[1]  = '{4'b0001, 32'hF0000000, 32'h0000000F, 1'b0, 32'hF000000F, 1'b0, 1'b0};
        av[2]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        av[3]  = '{4'b0011, 32'hAAAA5555, 32'hFFFF0000, 1'b0, 32'h55555555, 1'b0, 1'b0};
        av[4]  = '{4'b0110, 32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b1, 1'b1};
        av[5]  = '{4'b0110, 32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
        av[6]  = '{4'b0100, 32'h00000001, 32'h00000024, 1'b0, 32'h00000010, 1'b0, 1'b0};
        av[7]  = '{4'b0101, 32'h80000000, 32'h00000004, 1'b0, 32'h08000000, 1'b0, 1'b0};
        av[8]  = '{4'b1000, 32'h80000000, 32'h00000004, 1'b0, 32'hF8000000, 1'b0, 1'b0};
        av[9]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000001, 1'b0, 1'b0};
        av[10] = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b1};
        av[11] = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h00000000, 1'b1, 1'b1};
        av[12] = '{4'b1001, 32'h12345678, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};

        seg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        rst            = 1'b1;
        bus.estado     = 4'd0;
        bus.instrucao  = 32'd0;
        bus.readdata1R = 32'd0;
        bus.readdata2R = 32'd0;
        bus.alucontrol = 4'd0;
        bus.alusrc     = 1'b0;
        bus.branch     = 1'b0;
        bus.pc_lo      = 8'h3C;
        bus.x5_lo      = 8'hA5;
        bus.final_flag = 1'b1;
        #2;
        check_all_zero("reset");
        check("display1_in_reset", {25'd0, bus.display1}, {25'd0, 7'b1000110});
        tick();
        #3;
        rst = 1'b0;

        // Decode table
        foreach (dv[i]) begin
            bus.estado    = ST_ID;
            bus.instrucao = dv[i].instr;
            tick();
            check($sformatf("dec%0d.opcode", i), {25'd0, bus.opcode}, {25'd0, dv[i].opcode});
            check($sformatf("dec%0d.rd", i),     {27'd0, bus.rd},     {27'd0, dv[i].rd});
            check($sformatf("dec%0d.rs1", i),    {27'd0, bus.rs1},    {27'd0, dv[i].rs1});
            check($sformatf("dec%0d.rs2", i),    {27'd0, bus.rs2},    {27'd0, dv[i].rs2});
            check($sformatf("dec%0d.funct3", i), {29'd0, bus.funct3}, {29'd0, dv[i].funct3});
            check($sformatf("dec%0d.funct7", i), {25'd0, bus.funct7}, {25'd0, dv[i].funct7});
            check($sformatf("dec%0d.imm", i),    {20'd0, bus.immediate}, {20'd0, dv[i].imm});
            check($sformatf("dec%0d.tipo", i),   {29'd0, bus.tipo},   {29'd0, dv[i].tipo});
            check($sformatf("dec%0d.neg", i),    {31'd0, bus.negativo}, {31'd0, dv[i].neg});
        end

        // Decode holds outside ST_ID (last capture was dv[6])
        bus.estado    = 4'b0100;
        bus.instrucao = 32'h00500093;
        tick();
        check("dec_hold.opcode", {25'd0, bus.opcode}, {25'd0, 7'b0110111});
        check("dec_hold.tipo",   {29'd0, bus.tipo},   32'd7);

        // ALU table, register operand
        bus.alusrc = 1'b0;
        foreach (av[i]) begin
            bus.estado     = ST_EX;
            bus.alucontrol = av[i].ctrl;
            bus.readdata1R = av[i].a;
            bus.readdata2R = av[i].b;
            bus.branch     = av[i].br;
            tick();
            check($sformatf("alu%0d.result", i), bus.aluresult2, av[i].res);
            check($sformatf("alu%0d.zero", i),   {31'd0, bus.aluresult1}, {31'd0, av[i].zero});
            check($sformatf("alu%0d.pcsrc", i),  {31'd0, bus.pcsrc},      {31'd0, av[i].pcsrc});
        end

        // Immediate operand: addi with -1 then ADD 3 + (-1)
        bus.estado    = ST_ID;
        bus.instrucao = 32'hFFF00093;
        tick();
        check("imm_neg.imm", {20'd0, bus.immediate}, 32'h00000FFF);
        check("imm_neg.neg", {31'd0, bus.negativo}, 32'd1);
        bus.estado     = ST_EX;
        bus.alusrc     = 1'b1;
        bus.alucontrol = 4'b0010;
        bus.readdata1R = 32'd3;
        bus.readdata2R = 32'h55555555;
        bus.branch     = 1'b1;
        tick();
        check("imm_add.result", bus.aluresult2, 32'd2);
        check("imm_add.zero",   {31'd0, bus.aluresult1}, 32'd0);
        check("imm_add.pcsrc",  {31'd0, bus.pcsrc}, 32'd0);

        // ALU holds outside ST_EX
        bus.estado     = ST_ID;
        bus.readdata1R = 32'd100;
        tick();
        check("alu_hold_id.result", bus.aluresult2, 32'd2);
        bus.estado = 4'b1111;
        tick();
        check("alu_hold_other.result", bus.aluresult2, 32'd2);

        // Display sweep
        for (int d = 0; d < 16; d++) begin
            bus.pc_lo = {4'(15 - d), 4'(d)};
            bus.x5_lo = {4'(d), 4'(15 - d)};
            #1;
            check($sformatf("disp%0d.d1", d), {25'd0, bus.display1}, {25'd0, seg[d]});
            check($sformatf("disp%0d.d2", d), {25'd0, bus.display2}, {25'd0, seg[15 - d]});
            check($sformatf("disp%0d.d3", d), {25'd0, bus.display3}, {25'd0, seg[15 - d]});
            check($sformatf("disp%0d.d4", d), {25'd0, bus.display4}, {25'd0, seg[d]});
        end
        bus.pc_lo      = 8'h3C;
        bus.x5_lo      = 8'hA5;
        bus.final_flag = 1'b1;
        #1;
        check("disp_ex.d1", {25'd0, bus.display1}, {25'd0, 7'b1000110});
        check("disp_ex.d2", {25'd0, bus.display2}, {25'd0, 7'b0110000});
        check("disp_ex.d3", {25'd0, bus.display3}, {25'd0, 7'b0010010});
        check("disp_ex.d4", {25'd0, bus.display4}, {25'd0, 7'b0001000});
        check("disp_ex.d5", {25'd0, bus.display5}, {25'd0, 7'b1111001});
        bus.final_flag = 1'b0;
        #1;
        check("disp_final0.d5", {25'd0, bus.display5}, {25'd0, 7'b1000000});

        // Async reset between edges after a capture, then no update while held
        bus.estado    = ST_ID;
        bus.instrucao = 32'hFFC12283;
        tick();
        bus.estado     = ST_EX;
        bus.alusrc     = 1'b0;
        bus.alucontrol = 4'b0001;
        bus.readdata1R = 32'h0000F000;
        bus.readdata2R = 32'h0000000F;
        tick();
        check("pre_rst.result", bus.aluresult2, 32'h0000F00F);
        check("pre_rst.opcode", {25'd0, bus.opcode}, {25'd0, 7'b0000011});
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        bus.estado = ST_EX;
        tick();
        check_all_zero("rst_held_ex");
        bus.estado = ST_ID;
        tick();
        check_all_zero("rst_held_id");
        check("disp_in_rst.d1", {25'd0, bus.display1}, {25'd0, 7'b1000110});
        #2;
        rst = 1'b0;
        bus.estado = 4'd0;
        tick();
        check_all_zero("post_rst_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
